// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioning: 2-flop pad synchroniser, per-pin debounce on a shared prescaled tick,
// and registered rise/fall pulses when GPIO_EDGE_DET_EN is defined (tied low otherwise).
module gpio_in_conditioner #(
  parameter int NPINS      = 16,
  parameter int DB_SAMPLES = 3,
  parameter int PS_W       = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NPINS-1:0] PAD_IN,
  input  logic [NPINS-1:0] DB_EN,
  input  logic [PS_W-1:0]  PRESCALE,
  output logic [NPINS-1:0] WGPIODIN,
  output logic [NPINS-1:0] RISE,
  output logic [NPINS-1:0] FALL
);

  localparam int CNT_W = $clog2(DB_SAMPLES + 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_e;

  logic [NPINS-1:0] s1_q, s1_d;
  logic [NPINS-1:0] s2_q, s2_d;
  logic [NPINS-1:0] din_q, din_d;
  logic [PS_W-1:0]  pc_q, pc_d;
  logic             tick;

  db_state_e        state_q [NPINS];
  db_state_e        state_d [NPINS];
  logic [CNT_W-1:0] cnt_q   [NPINS];
  logic [CNT_W-1:0] cnt_d   [NPINS];

  // Synchroniser and prescaler next state.
  always_comb begin
    s1_d = PAD_IN;
    s2_d = s1_q;
    // Comparing against the live PRESCALE means lowering it below pc ticks at once
    // instead of wrapping through the full counter range.
    tick = (pc_q >= PRESCALE);
    pc_d = tick ? '0 : pc_q + PS_W'(1);
  end

  // NOTE: every output of this block is given a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    din_d = din_q;
    for (int i = 0; i < NPINS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!DB_EN[i]) begin
        din_d[i]   = s2_q[i];
        state_d[i] = ST_STABLE;
        cnt_d[i]   = '0;
      end else if (tick) begin
        case (state_q[i])
          ST_STABLE: begin
            if (s2_q[i] != din_q[i]) begin
              if (DB_SAMPLES == 1) begin
                din_d[i] = s2_q[i];
              end else begin
                state_d[i] = ST_COUNT;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          ST_COUNT: begin
            if (s2_q[i] == din_q[i]) begin
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else if (int'(cnt_q[i]) + 1 == DB_SAMPLES) begin
              din_d[i]   = s2_q[i];
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_q  <= '0;
      s2_q  <= '0;
      din_q <= '0;
      pc_q  <= '0;
      for (int i = 0; i < NPINS; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      din_q <= din_d;
      pc_q  <= pc_d;
      for (int i = 0; i < NPINS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign WGPIODIN = din_q;

`ifdef GPIO_EDGE_DET_EN
  logic [NPINS-1:0] dq_q, dq_d;
  logic [NPINS-1:0] rise_q, rise_d;
  logic [NPINS-1:0] fall_q, fall_d;

  // Pulses appear the cycle after WGPIODIN changes and last exactly one cycle.
  always_comb begin
    dq_d   = din_q;
    rise_d = din_q & ~dq_q;
    fall_d = ~din_q & dq_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dq_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      dq_q   <= dq_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`else
  assign RISE = '0;
  assign FALL = '0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: directed scenarios plus random pad traffic,
// compared against a cycle-level behavioural model of the conditioning rules.
module tb_gpio_in_conditioner;

  localparam int NPINS      = 16;
  localparam int DB_SAMPLES = 3;
  localparam int PS_W       = 16;

  logic             HCLK;
  logic             HRESETn;
  logic [NPINS-1:0] PAD_IN;
  logic [NPINS-1:0] DB_EN;
  logic [PS_W-1:0]  PRESCALE;
  logic [NPINS-1:0] WGPIODIN;
  logic [NPINS-1:0] RISE;
  logic [NPINS-1:0] FALL;

  gpio_in_conditioner #(
    .NPINS     (NPINS),
    .DB_SAMPLES(DB_SAMPLES),
    .PS_W      (PS_W)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PAD_IN  (PAD_IN),
    .DB_EN   (DB_EN),
    .PRESCALE(PRESCALE),
    .WGPIODIN(WGPIODIN),
    .RISE    (RISE),
    .FALL    (FALL)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;

  // Model: pad delay line, conditioned level and its two previous values,
  // cycles since last tick, and consecutive differing ticks per pin.
  logic [NPINS-1:0] m_s1, m_s2, m_out, m_out_d1, m_out_d2;
  int               m_pc;
  int               m_run [NPINS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NPINS-1:0] exp_rise();
`ifdef GPIO_EDGE_DET_EN
    return m_out_d1 & ~m_out_d2;
`else
    return '0;
`endif
  endfunction

  function automatic logic [NPINS-1:0] exp_fall();
`ifdef GPIO_EDGE_DET_EN
    return ~m_out_d1 & m_out_d2;
`else
    return '0;
`endif
  endfunction

  task automatic reset_model();
    m_s1 = '0; m_s2 = '0; m_out = '0; m_out_d1 = '0; m_out_d2 = '0; m_pc = 0;
    for (int i = 0; i < NPINS; i++) m_run[i] = 0;
  endtask

  task automatic compare_all();
    check("wgpiodin", 32'(WGPIODIN), 32'(m_out));
    check("rise",     32'(RISE),     32'(exp_rise()));
    check("fall",     32'(FALL),     32'(exp_fall()));
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic step();
    logic [NPINS-1:0] out_n;
    bit               tick;
    tick  = (m_pc >= int'(PRESCALE));
    out_n = m_out;
    for (int i = 0; i < NPINS; i++) begin
      if (!DB_EN[i]) begin
        out_n[i] = m_s2[i];
        m_run[i] = 0;
      end else if (tick) begin
        if (m_s2[i] != m_out[i]) begin
          m_run[i]++;
          if (m_run[i] >= DB_SAMPLES) begin
            out_n[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_pc     = tick ? 0 : m_pc + 1;
    m_out_d2 = m_out_d1;
    m_out_d1 = m_out;
    m_out    = out_n;
    m_s2     = m_s1;
    m_s1     = PAD_IN;
    @(posedge HCLK);
    #1;
    compare_all();
  endtask

  bit edge_on;
  int rise_cnt;
  int n;

  initial begin
`ifdef GPIO_EDGE_DET_EN
    edge_on = 1'b1;
`else
    edge_on = 1'b0;
`endif
    HRESETn  = 1'b0;
    PAD_IN   = '0;
    DB_EN    = '0;
    PRESCALE = '0;
    reset_model();
    #12;
    check("reset_wgpiodin", 32'(WGPIODIN), 32'h0);
    check("reset_rise",     32'(RISE),     32'h0);
    check("reset_fall",     32'(FALL),     32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Bypass latency on pin 0.
    PAD_IN[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("byp_lat_w",    32'(WGPIODIN[0]), 32'(k >= 3));
      check("byp_lat_rise", 32'(RISE[0]),     32'(edge_on && k == 4));
      check("byp_lat_fall", 32'(FALL[0]),     32'h0);
    end
    PAD_IN[0] = 1'b0;
    repeat (6) step();

    // Debounce accept on pin 3 with PRESCALE=4.
    DB_EN    = 16'h0008;
    PRESCALE = 16'd4;
    PAD_IN[3] = 1'b1;
    rise_cnt = 0;
    for (n = 0; n < 30; n++) begin
      step();
      if (RISE[3]) rise_cnt++;
    end
    check("db_accept_w",     32'(WGPIODIN[3]), 32'h1);
    check("db_accept_pulse", 32'(rise_cnt),    32'(edge_on ? 1 : 0));

    // Return low, then glitch of 7 cycles must be rejected.
    PAD_IN[3] = 1'b0;
    repeat (25) step();
    check("db_return_w", 32'(WGPIODIN[3]), 32'h0);
    PAD_IN[3] = 1'b1;
    rise_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (RISE[3]) rise_cnt++;
    end
    PAD_IN[3] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (RISE[3]) rise_cnt++;
      check("glitch_w", 32'(WGPIODIN[3]), 32'h0);
    end
    check("glitch_no_rise", 32'(rise_cnt), 32'h0);

    // PRESCALE=0: debounced pin follows s2 exactly DB_SAMPLES cycles later.
    PRESCALE  = 16'd0;
    PAD_IN[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("ps0_w", 32'(WGPIODIN[3]), 32'(k >= 2 + DB_SAMPLES));
    end

    // Lower PRESCALE from 100 to 2 while the prescaler sits at 50.
    PRESCALE = 16'd100;
    for (n = 0; n < 150 && m_pc != 40; n++) step();
    check("ps_reach_40", 32'(m_pc == 40), 32'h1);
    PAD_IN[3] = 1'b0;
    for (n = 0; n < 150 && m_pc != 50; n++) step();
    check("ps_reach_50", 32'(m_pc == 50), 32'h1);
    PRESCALE = 16'd2;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("ps_change_w", 32'(WGPIODIN[3]), 32'(k < 7));
    end

    // DB_EN 1->0 mid-count: pin switches to bypass on the next edge.
    PRESCALE  = 16'd4;
    PAD_IN[3] = 1'b1;
    for (n = 0; n < 20 && m_run[3] != 1; n++) step();
    check("mid_cnt_reached", 32'(m_run[3] == 1), 32'h1);
    check("mid_cnt_still_0", 32'(WGPIODIN[3]),   32'h0);
    DB_EN[3] = 1'b0;
    step();
    check("db_off_bypass", 32'(WGPIODIN[3]), 32'h1);

    // Random pad traffic with varying enables and prescaler.
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin
        DB_EN    = NPINS'($urandom);
        PRESCALE = PS_W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) PAD_IN = PAD_IN ^ NPINS'($urandom & $urandom);
      step();
    end

    // All 16 pins toggled together in bypass.
    DB_EN  = '0;
    PAD_IN = 16'hFFFF;
    repeat (6) step();
    PAD_IN = 16'h0000;
    repeat (6) step();

    // Reset while pin 0 has counted two ticks.
    DB_EN    = 16'hFFFF;
    PRESCALE = 16'd0;
    repeat (10) step();
    PAD_IN = 16'hFFFF;
    for (n = 0; n < 10 && m_run[0] != 2; n++) step();
    check("rst_cnt_reached", 32'(m_run[0] == 2), 32'h1);
    #2;
    HRESETn = 1'b0;
    reset_model();
    #1;
    check("midrst_wgpiodin", 32'(WGPIODIN), 32'h0);
    check("midrst_rise",     32'(RISE),     32'h0);
    check("midrst_fall",     32'(FALL),     32'h0);
    @(negedge HCLK);
    PAD_IN  = '0;
    HRESETn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_rise", 32'(RISE), 32'h0);
      check("post_rst_fall", 32'(FALL), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Input-conditioning stage directly upstream of the AHB-Lite GPIO register block.
- Takes raw asynchronous pad inputs, double-flop synchronises them, optionally debounces each pin against a shared prescaled sample tick, and drives the clean per-pin levels into the GPIO block's WGPIODIN input.
- Also produces per-pin single-cycle rise/fall pulses for the interrupt logic.

Parameters:
- NPINS, 16, number of GPIO pins; must not exceed 32.
- DB_SAMPLES, 3, consecutive differing ticks needed before a debounced pin changes; legal range 1-15.
- PS_W, 16, width of the PRESCALE input.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  reset; asynchronous assert, active-low.
- PAD_IN  input  NPINS  raw pad inputs, asynchronous to HCLK.
- DB_EN  input  NPINS  per-pin debounce enable; 0 = bypass.
- PRESCALE  input  PS_W  sample tick period minus 1.
- WGPIODIN  output  NPINS  conditioned pin levels, fed to the GPIO block.
- RISE  output  NPINS  one-cycle pulse per pin on a WGPIODIN 0->1 transition.
- FALL  output  NPINS  one-cycle pulse per pin on a WGPIODIN 1->0 transition.

Behaviour:
- Reset: sync stage 1 and 2, WGPIODIN, per-pin counters, prescaler, RISE, FALL all go to 0.
- Synchroniser: per pin, s1 <= PAD_IN; s2 <= s1. Nothing downstream uses s1 or PAD_IN.
- Prescaler:
  - Free-running counter pc.
  - If pc >= PRESCALE: tick = 1 for this cycle and pc <= 0. Otherwise pc <= pc+1.
  - PRESCALE=0 gives a tick every cycle.
  - Lowering PRESCALE below the current pc causes a tick on the next cycle; no wrap-around through 2^PS_W.
- Bypass pin (DB_EN[i]=0):
  - WGPIODIN[i] <= s2[i] every cycle.
  - Counter cnt[i] held at 0.
  - Latency: PAD change set up before edge 0 appears on WGPIODIN after edge 3.
- Debounced pin (DB_EN[i]=1), per-pin state machine:
  - State STABLE (cnt=0):
    - On tick with s2 != WGPIODIN: go to COUNT, cnt=1.
    - If DB_SAMPLES=1: WGPIODIN[i] <= s2 immediately on that tick, stay STABLE.
  - State COUNT:
    - On tick with s2 == WGPIODIN: return to STABLE, cnt=0 (glitch rejected).
    - On tick with s2 != WGPIODIN and cnt+1 == DB_SAMPLES: WGPIODIN[i] <= s2, cnt=0, go to STABLE.
    - On tick otherwise: cnt++.
    - No tick: hold.
  - cnt is ceil(log2(DB_SAMPLES+1)) bits and never exceeds DB_SAMPLES-1.
- DB_EN changes:
  - DB_EN[i] 1->0 mid-count: cnt cleared; pin switches to bypass next cycle.
  - DB_EN[i] 0->1: starts in STABLE.
- Edge detect:
  - dq <= WGPIODIN.
  - RISE = WGPIODIN & ~dq; FALL = ~WGPIODIN & dq.
  - Each pulse is high for exactly one cycle, the cycle after WGPIODIN changes.
  - RISE and FALL are never both high for the same pin.
  - Pad high at reset release: WGPIODIN rises 3 cycles later with a RISE pulse. This is required behaviour, not suppressed.
- Reset mid-operation: all state cleared immediately; no pulse is generated by reset itself.
- All pins are independent; only the prescaler is shared.

Optional Feature:
- Macro GPIO_EDGE_DET_EN.
- Defined: dq registers and RISE/FALL logic present as above.
- Undefined: dq removed; RISE and FALL tied to all-zero; WGPIODIN behaviour identical.

Test Plan:
- Bypass latency: DB_EN=0, PAD_IN[0] 0->1 before edge 0 -> WGPIODIN[0]=1 after edge 3; RISE[0]=1 for exactly one cycle after edge 4 (with GPIO_EDGE_DET_EN); FALL stays 0.
- Debounce accept: DB_EN[3]=1, PRESCALE=4, DB_SAMPLES=3, PAD_IN[3] held high -> WGPIODIN[3] rises on the 3rd tick after s2 goes high (10-15 cycles after the change depending on prescaler phase); single RISE[3] pulse.
- Glitch reject: same setup, PAD_IN[3] high for 7 cycles then low -> at most 2 ticks counted; WGPIODIN[3] stays 0; RISE[3] never pulses.
- Prescaler boundary: PRESCALE=0 -> tick every cycle; debounced pin changes exactly DB_SAMPLES cycles after s2 changes. Changing PRESCALE from 100 to 2 while pc=50 -> tick next cycle, then every 3 cycles.
- Mid-operation events: assert HRESETn low while cnt=2 -> all outputs 0 immediately with no pulses; separately, DB_EN 1->0 mid-count -> pin follows s2 next cycle.
- Macro off: compile without GPIO_EDGE_DET_EN, toggle all 16 pins -> RISE=FALL=16'h0000 throughout; WGPIODIN matches the macro-on run cycle for cycle.
